// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS control unit, its datapath and
// the ALU control block: opcode values, ALU operation codes, FSM state
// encodings, datapath selector codes and the packed control-vector type.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  // ALU operation codes handed to ALU control
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  // FSM state encodings; 14 and 15 are unreachable
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_FETCH    = 4'd1;
  localparam state_t ST_DECODE   = 4'd2;
  localparam state_t ST_EXEC_R   = 4'd3;
  localparam state_t ST_WB_R     = 4'd4;
  localparam state_t ST_EXEC_I   = 4'd5;
  localparam state_t ST_WB_I     = 4'd6;
  localparam state_t ST_MEM_ADDR = 4'd7;
  localparam state_t ST_MEM_RD   = 4'd8;
  localparam state_t ST_MEM_WB   = 4'd9;
  localparam state_t ST_MEM_WR   = 4'd10;
  localparam state_t ST_BRANCH   = 4'd11;
  localparam state_t ST_JUMP     = 4'd12;
  localparam state_t ST_JAL_WB   = 4'd13;

  // Register-file destination select
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  // Register-file write-data select
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // ALU B-operand select
  localparam logic [1:0] ALUB_B    = 2'd0;
  localparam logic [1:0] ALUB_FOUR = 2'd1;
  localparam logic [1:0] ALUB_SEXT = 2'd2;
  localparam logic [1:0] ALUB_SHL2 = 2'd3;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // One control word per state, before the FETCH stall gate is applied
  typedef struct packed {
    logic       pcWrite;
    logic       branchEq;
    logic       branchNe;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] regDst;
    logic [1:0] memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
  } ctrl_vec_t;

  localparam ctrl_vec_t CTRL_IDLE = ctrl_vec_t'(21'd0);

  // True for every opcode the FSM knows how to sequence
  function automatic logic opIsLegal(input logic [5:0] opc);
    logic legal;
    case (opc)
      OPC_RTYPE, OPC_J, OPC_JAL, OPC_BEQ, OPC_BNE,
      OPC_ADDI, OPC_ORI, OPC_LUI, OPC_LW, OPC_SW: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_if
// Control bus between the multi-cycle control FSM and the shared-memory
// datapath. The master (FSM) consumes op/mem_ready and drives every control
// strobe/select; the slave (datapath) is the mirror image.
//   op, mem_ready                      : datapath -> FSM
//   pc_write .. pc_source, illegal_op  : FSM -> datapath
// ---------------------------------------------------------------------------
interface multicycle_control_fsm_if #(
  parameter int OP_WIDTH    = 6,
  parameter int ALUOP_WIDTH = 3
);
  logic [OP_WIDTH-1:0]    op;
  logic                   mem_ready;
  logic                   pc_write;
  logic                   branch_eq;
  logic                   branch_ne;
  logic                   i_or_d;
  logic                   mem_read;
  logic                   mem_write;
  logic                   ir_write;
  logic [1:0]             reg_dst;
  logic [1:0]             mem_to_reg;
  logic                   reg_write;
  logic                   alu_src_a;
  logic [1:0]             alu_src_b;
  logic [ALUOP_WIDTH-1:0] alu_op;
  logic [1:0]             pc_source;
  logic                   illegal_op;

  modport master (
    input  op, mem_ready,
    output pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_source, illegal_op
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, pc_source, illegal_op
  );
endinterface

// File: rtl/ctrl_output_decode.sv
// ---------------------------------------------------------------------------
// ctrl_output_decode
// Combinational state -> control-vector ROM for the multi-cycle control FSM.
//   state     : current FSM state
//   opLatched : opcode captured in DECODE (selects ALU op in EXEC_I and the
//               branch sense in BRANCH)
//   ctrl      : control word for this state
// ---------------------------------------------------------------------------
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opLatched,
  output ctrl_vec_t  ctrl
);

  // State ROM: every unlisted state leaves all controls at zero
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      ST_FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.irWrite  = 1'b1;
        ctrl.aluSrcA  = 1'b0;
        ctrl.aluSrcB  = ALUB_FOUR;
        ctrl.aluOp    = ALU_ADD;
        ctrl.pcSource = PCSRC_ALU;
        ctrl.pcWrite  = 1'b1;
      end
      ST_DECODE: begin
        // Speculative branch target PC + (imm << 2) into ALUOut
        ctrl.aluSrcA = 1'b0;
        ctrl.aluSrcB = ALUB_SHL2;
        ctrl.aluOp   = ALU_ADD;
      end
      ST_EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = ALUB_B;
        ctrl.aluOp   = ALU_FUNCT;
      end
      ST_WB_R: begin
        ctrl.regDst   = REG_DST_RD;
        ctrl.memToReg = M2R_ALUOUT;
        ctrl.regWrite = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = ALUB_SEXT;
        case (opLatched)
          OPC_ORI: ctrl.aluOp = ALU_OR;
          OPC_LUI: ctrl.aluOp = ALU_LUI;
          default: ctrl.aluOp = ALU_ADD;
        endcase
      end
      ST_WB_I: begin
        ctrl.regDst   = REG_DST_RT;
        ctrl.memToReg = M2R_ALUOUT;
        ctrl.regWrite = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = ALUB_SEXT;
        ctrl.aluOp   = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl.iOrD    = 1'b1;
        ctrl.memRead = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.regDst   = REG_DST_RT;
        ctrl.memToReg = M2R_MDR;
        ctrl.regWrite = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.iOrD     = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.aluSrcA  = 1'b1;
        ctrl.aluSrcB  = ALUB_B;
        ctrl.aluOp    = ALU_SUB;
        ctrl.pcSource = PCSRC_ALUOUT;
        ctrl.branchEq = (opLatched == OPC_BEQ);
        ctrl.branchNe = (opLatched == OPC_BNE);
      end
      ST_JUMP: begin
        ctrl.pcSource = PCSRC_JUMP;
        ctrl.pcWrite  = 1'b1;
      end
      ST_JAL_WB: begin
        // PC already holds PC+4 from FETCH, so it is the link value
        ctrl.regDst   = REG_DST_RA;
        ctrl.memToReg = M2R_PC;
        ctrl.regWrite = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
        ctrl.pcWrite  = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Multi-cycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB
// with memory wait-state handshaking.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; returns to IDLE with all controls low
//   bus   : control bus (master side) -- op, mem_ready in; all datapath
//           strobes/selects and the illegal_op pulse out
// Parameters: OP_WIDTH (opcode width), ALUOP_WIDTH (alu_op width),
//             MEM_WAIT_EN (1: FETCH/MEM_RD/MEM_WR wait for mem_ready).
// ---------------------------------------------------------------------------
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OP_WIDTH    = 6,
  parameter int ALUOP_WIDTH = 3,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_control_fsm_if.master bus
);

  state_t     stateR;
  state_t     stateNextS;
  logic [5:0] opS;
  logic [5:0] opR;
  logic       memDoneS;
  ctrl_vec_t  ctrlS;
  ctrl_vec_t  ctrlOutS;
  logic       illegalS;

  assign opS = 6'(bus.op);

  // Memory-complete qualifier; with waits disabled every access finishes at once
  always_comb begin
    if (MEM_WAIT_EN) begin
      memDoneS = bus.mem_ready;
    end else begin
      memDoneS = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR <= ST_IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Opcode captured in DECODE so later states never depend on the live op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opR <= 6'h00;
    end else if (stateR == ST_DECODE) begin
      opR <= opS;
    end else begin
      opR <= opR;
    end
  end

  // Next-state logic
  always_comb begin
    stateNextS = ST_FETCH;
    case (stateR)
      ST_IDLE:  stateNextS = ST_FETCH;
      ST_FETCH: stateNextS = memDoneS ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opS)
          OPC_RTYPE:                  stateNextS = ST_EXEC_R;
          OPC_ADDI, OPC_ORI, OPC_LUI: stateNextS = ST_EXEC_I;
          OPC_LW, OPC_SW:             stateNextS = ST_MEM_ADDR;
          OPC_BEQ, OPC_BNE:           stateNextS = ST_BRANCH;
          OPC_J:                      stateNextS = ST_JUMP;
          OPC_JAL:                    stateNextS = ST_JAL_WB;
          default:                    stateNextS = ST_FETCH;
        endcase
      end
      ST_EXEC_R: stateNextS = ST_WB_R;
      ST_WB_R:   stateNextS = ST_FETCH;
      ST_EXEC_I: stateNextS = ST_WB_I;
      ST_WB_I:   stateNextS = ST_FETCH;
      ST_MEM_ADDR: begin
        if (opR == OPC_LW) begin
          stateNextS = ST_MEM_RD;
        end else if (opR == OPC_SW) begin
          stateNextS = ST_MEM_WR;
        end else begin
          stateNextS = ST_FETCH;
        end
      end
      ST_MEM_RD: stateNextS = memDoneS ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB: stateNextS = ST_FETCH;
      ST_MEM_WR: stateNextS = memDoneS ? ST_FETCH : ST_MEM_WR;
      ST_BRANCH: stateNextS = ST_FETCH;
      ST_JUMP:   stateNextS = ST_FETCH;
      ST_JAL_WB: stateNextS = ST_FETCH;
      default:   stateNextS = ST_FETCH;
    endcase
  end

  ctrl_output_decode uDecode (
    .state     (stateR),
    .opLatched (opR),
    .ctrl      (ctrlS)
  );

  // A stalled fetch keeps reading but must not load IR or advance PC
  always_comb begin
    ctrlOutS = ctrlS;
    if ((stateR == ST_FETCH) && !memDoneS) begin
      ctrlOutS.irWrite = 1'b0;
      ctrlOutS.pcWrite = 1'b0;
    end else begin
      ctrlOutS = ctrlS;
    end
  end

  // Illegal opcode is flagged only during the single DECODE cycle
  always_comb begin
    if (stateR == ST_DECODE) begin
      illegalS = !opIsLegal(opS);
    end else begin
      illegalS = 1'b0;
    end
  end

  assign bus.pc_write   = ctrlOutS.pcWrite;
  assign bus.branch_eq  = ctrlOutS.branchEq;
  assign bus.branch_ne  = ctrlOutS.branchNe;
  assign bus.i_or_d     = ctrlOutS.iOrD;
  assign bus.mem_read   = ctrlOutS.memRead;
  assign bus.mem_write  = ctrlOutS.memWrite;
  assign bus.ir_write   = ctrlOutS.irWrite;
  assign bus.reg_dst    = ctrlOutS.regDst;
  assign bus.mem_to_reg = ctrlOutS.memToReg;
  assign bus.reg_write  = ctrlOutS.regWrite;
  assign bus.alu_src_a  = ctrlOutS.aluSrcA;
  assign bus.alu_src_b  = ctrlOutS.aluSrcB;
  assign bus.alu_op     = ALUOP_WIDTH'(ctrlOutS.aluOp);
  assign bus.pc_source  = ctrlOutS.pcSource;
  assign bus.illegal_op = illegalS;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Directed self-checking bench for multicycle_control_fsm. Each cycle the
// full control word is compared against a hand-built expected word.
// Word layout: {pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
//               ir_write, reg_dst[1:0], mem_to_reg[1:0], reg_write,
//               alu_src_a, alu_src_b[1:0], alu_op[2:0], pc_source[1:0],
//               illegal_op}
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic clk;
  logic reset;
  int   errCount;
  int   checkCount;

  multicycle_control_fsm_if #(.OP_WIDTH(6), .ALUOP_WIDTH(3)) bus ();

  multicycle_control_fsm #(
    .OP_WIDTH    (6),
    .ALUOP_WIDTH (3),
    .MEM_WAIT_EN (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] obsWord;
  assign obsWord = {bus.pc_write, bus.branch_eq, bus.branch_ne, bus.i_or_d,
                    bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                    bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal_op};

  function automatic logic [20:0] cw(
    input logic pcw, input logic beq, input logic bne, input logic iod,
    input logic mr, input logic mw, input logic irw, input logic [1:0] rd,
    input logic [1:0] m2r, input logic rw, input logic asa,
    input logic [1:0] asb, input logic [2:0] aop, input logic [1:0] psrc,
    input logic ill);
    return {pcw, beq, bne, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, ill};
  endfunction

  task automatic checkVal(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  task automatic stepCheck(input string tag, input logic [20:0] exp);
    @(posedge clk);
    #1;
    checkVal(tag, obsWord, exp);
  endtask

  logic [20:0] eZero, eFetch, eFetchStall, eDecode, eDecodeIll;
  logic [20:0] eExecR, eWbR, eExecAdd, eExecOr, eExecLui, eWbI;
  logic [20:0] eMemAddr, eMemRd, eMemWb, eMemWr, eBeq, eBne, eJump, eJal;

  initial begin
    errCount   = 0;
    checkCount = 0;
    //                pcw  beq  bne  iod  mr   mw   irw  rd    m2r   rw   asa  asb   aop     psrc  ill
    eZero       = 21'd0;
    eFetch      = cw(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'd0,2'd0,1'b0,1'b0,2'd1,3'b100,2'd0,1'b0);
    eFetchStall = cw(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd1,3'b100,2'd0,1'b0);
    eDecode     = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd3,3'b100,2'd0,1'b0);
    eDecodeIll  = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd3,3'b100,2'd0,1'b1);
    eExecR      = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd0,3'b111,2'd0,1'b0);
    eWbR        = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,1'b1,1'b0,2'd0,3'b000,2'd0,1'b0);
    eExecAdd    = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd2,3'b100,2'd0,1'b0);
    eExecOr     = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd2,3'b101,2'd0,1'b0);
    eExecLui    = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd2,3'b110,2'd0,1'b0);
    eWbI        = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,1'b0,2'd0,3'b000,2'd0,1'b0);
    eMemAddr    = eExecAdd;
    eMemRd      = cw(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,3'b000,2'd0,1'b0);
    eMemWb      = cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,1'b1,1'b0,2'd0,3'b000,2'd0,1'b0);
    eMemWr      = cw(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,3'b000,2'd0,1'b0);
    eBeq        = cw(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd0,3'b010,2'd1,1'b0);
    eBne        = cw(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd0,3'b010,2'd1,1'b0);
    eJump       = cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,3'b000,2'd2,1'b0);
    eJal        = cw(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd2,1'b1,1'b0,2'd0,3'b000,2'd2,1'b0);

    // Reset held for 3 cycles, then released: IDLE, then FETCH
    reset         = 1'b1;
    bus.op        = 6'h08;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset_held", obsWord, eZero);
    reset = 1'b0;
    #1;
    checkVal("idle_after_release", obsWord, eZero);
    stepCheck("first_fetch", eFetch);

    // ADDI: FETCH, DECODE, EXEC_I, WB_I, FETCH on cycle 5
    stepCheck("addi_decode", eDecode);
    stepCheck("addi_exec", eExecAdd);
    stepCheck("addi_wb", eWbI);
    stepCheck("addi_next_fetch", eFetch);

    // ORI and LUI select their own ALU codes in EXEC_I
    bus.op = 6'h0d;
    stepCheck("ori_decode", eDecode);
    stepCheck("ori_exec", eExecOr);
    stepCheck("ori_wb", eWbI);
    stepCheck("ori_next_fetch", eFetch);
    bus.op = 6'h0f;
    stepCheck("lui_decode", eDecode);
    stepCheck("lui_exec", eExecLui);
    stepCheck("lui_wb", eWbI);
    stepCheck("lui_next_fetch", eFetch);

    // R-type
    bus.op = 6'h00;
    stepCheck("r_decode", eDecode);
    stepCheck("r_exec", eExecR);
    stepCheck("r_wb", eWbR);
    stepCheck("r_next_fetch", eFetch);

    // LW with mem_ready low for the first two MEM_RD cycles: 7 cycles total
    bus.op = 6'h23;
    stepCheck("lw_decode", eDecode);
    stepCheck("lw_mem_addr", eMemAddr);
    bus.mem_ready = 1'b0;
    stepCheck("lw_mem_rd_1", eMemRd);
    stepCheck("lw_mem_rd_2", eMemRd);
    bus.mem_ready = 1'b1;
    #1;
    checkVal("lw_mem_rd_3", obsWord, eMemRd);
    stepCheck("lw_mem_wb", eMemWb);
    stepCheck("lw_next_fetch", eFetch);

    // Stalled FETCH keeps mem_read but gates ir_write/pc_write
    bus.mem_ready = 1'b0;
    #1;
    checkVal("fetch_stall_1", obsWord, eFetchStall);
    stepCheck("fetch_stall_2", eFetchStall);
    bus.mem_ready = 1'b1;
    #1;
    checkVal("fetch_stall_release", obsWord, eFetch);

    // SW completing without wait
    bus.op = 6'h2b;
    stepCheck("sw_decode", eDecode);
    stepCheck("sw_mem_addr", eMemAddr);
    stepCheck("sw_mem_wr", eMemWr);
    stepCheck("sw_next_fetch", eFetch);

    // BEQ / BNE
    bus.op = 6'h04;
    stepCheck("beq_decode", eDecode);
    stepCheck("beq_branch", eBeq);
    stepCheck("beq_next_fetch", eFetch);
    bus.op = 6'h05;
    stepCheck("bne_decode", eDecode);
    stepCheck("bne_branch", eBne);
    stepCheck("bne_next_fetch", eFetch);

    // J / JAL
    bus.op = 6'h02;
    stepCheck("j_decode", eDecode);
    stepCheck("j_jump", eJump);
    stepCheck("j_next_fetch", eFetch);
    bus.op = 6'h03;
    stepCheck("jal_decode", eDecode);
    stepCheck("jal_wb", eJal);
    stepCheck("jal_next_fetch", eFetch);

    // Illegal opcode: one-cycle pulse in DECODE, then FETCH
    bus.op = 6'h3f;
    stepCheck("illegal_decode", eDecodeIll);
    stepCheck("illegal_next_fetch", eFetch);

    // SW held in MEM_WR, then async reset mid-cycle
    bus.op = 6'h2b;
    stepCheck("sw2_decode", eDecode);
    stepCheck("sw2_mem_addr", eMemAddr);
    bus.mem_ready = 1'b0;
    stepCheck("sw2_mem_wr_1", eMemWr);
    stepCheck("sw2_mem_wr_held", eMemWr);
    #2;
    reset = 1'b1;
    #1;
    checkVal("async_reset_mem_wr", obsWord, eZero);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    checkVal("reset_still_idle", obsWord, eZero);
    reset = 1'b0;
    #1;
    checkVal("post_reset_idle", obsWord, eZero);
    stepCheck("post_reset_fetch", eFetch);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
